sm_addsub_serial: RTL

//  Bit-serial sign-magnitude adder/subtractor (r = a +/- b). Inverse direction of the

---
 rtl/sm_addsub_serial.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sm_addsub_serial.sv
// Bit-serial sign-magnitude adder/subtractor: r = a +/- b.
// Operands go through two's complement internally, are added LSB first, then converted back.
module sm_addsub_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m,
  input  logic             a_sign,
  input  logic [WIDTH-1:0] a_mag,
  input  logic             b_sign,
  input  logic [WIDTH-1:0] b_mag,
  output logic             busy,
  output logic             done,
  output logic             r_sign,
  output logic [WIDTH:0]   r_mag
);

  localparam int unsigned IW = WIDTH + 2;
  localparam int unsigned MW = WIDTH + 1;
  localparam int unsigned CW = $clog2(IW);

  typedef enum logic [2:0] {StIdle, StConv, StAdd, StFix, StDone} state_e;

  state_e          state_q;
  logic [IW-1:0]   a_q;
  logic [IW-1:0]   b_q;
  logic [IW-1:0]   sum_q;
  logic            c_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_a_q;
  logic            neg_b_q;
  logic            busy_q;
  logic            done_q;
  logic            r_sign_q;
  logic [WIDTH:0]  r_mag_q;

  logic s_bit;
  logic c_nxt;

  always_comb begin
    s_bit = a_q[0] ^ b_q[0] ^ c_q;
    c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_sign_q <= 1'b0;
      r_mag_q  <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= IW'(a_mag);
            b_q     <= IW'(b_mag);
            neg_a_q <= a_sign;
            // Subtraction folds into the sign of b.
            neg_b_q <= b_sign ^ m;
            busy_q  <= 1'b1;
            state_q <= StConv;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StConv: begin
          a_q     <= neg_a_q ? (~a_q + IW'(1)) : a_q;
          b_q     <= neg_b_q ? (~b_q + IW'(1)) : b_q;
          c_q     <= 1'b0;
          cnt_q   <= '0;
          state_q <= StAdd;
        end
        StAdd: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_nxt;
          sum_q <= {s_bit, sum_q[IW-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(IW - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // Low bits of -sum equal the negation of the low bits alone.
          if (sum_q[IW-1]) begin
            r_mag_q  <= ~sum_q[WIDTH:0] + MW'(1);
            r_sign_q <= 1'b1;
          end else begin
            r_mag_q  <= sum_q[WIDTH:0];
            r_sign_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign r_sign = r_sign_q;
  assign r_mag  = r_mag_q;

endmodule
